// File: rtl/spi_bus_arbiter_if.sv
// Requester-side and shared-SPI-master signals of spi_bus_arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface spi_bus_arbiter_if;
  logic [1:0] req;
  logic [1:0] xfer;
  logic [7:0] tx_byte0;
  logic [7:0] tx_byte1;
  logic [1:0] gnt;
  logic [1:0] done_o;
  logic [7:0] rx_byte;
  logic       spi_transmit;
  logic [7:0] spi_to_send;
  logic       spi_done;
  logic [7:0] spi_received;
  logic       timeout_err;

  modport master (
    input  req, xfer, tx_byte0, tx_byte1, spi_done, spi_received,
    output gnt, done_o, rx_byte, spi_transmit, spi_to_send, timeout_err
  );

  modport slave (
    output req, xfer, tx_byte0, tx_byte1, spi_done, spi_received,
    input  gnt, done_o, rx_byte, spi_transmit, spi_to_send, timeout_err
  );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Two-requester arbiter in front of one shared SPI master, one byte per xfer handshake.
// Optional XFER watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  spi_bus_arbiter_if.master bus
);

  typedef enum logic [2:0] {IDLE, OWN, LOAD, XFER, ACK} state_t;

  state_t     r_state, w_state_nxt;
  logic       r_owner, w_owner_nxt;
  logic       r_last_owner, w_last_owner_nxt;
  logic [7:0] r_to_send, w_to_send_nxt;
  logic [7:0] r_rx_byte, w_rx_byte_nxt;
  logic       r_spi_done_q;
  logic       w_done_rise;
  logic       w_timeout;
  logic [7:0] w_tx_sel;
  logic [1:0] w_owner_oh;

  assign w_done_rise = bus.spi_done & ~r_spi_done_q;
  assign w_tx_sel    = r_owner ? bus.tx_byte1 : bus.tx_byte0;
  assign w_owner_oh  = r_owner ? 2'b10 : 2'b01;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_timeout_err;

  // The TIMEOUT_CYCLES-th edge spent in XFER aborts; a simultaneous spi_done edge wins.
  assign w_timeout = (r_state == XFER) && !w_done_rise &&
                     (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;
      if (r_state == XFER) r_cnt <= r_cnt + 1'b1;
      else                 r_cnt <= '0;
    end
  end

  assign bus.timeout_err = r_timeout_err;
`else
  logic w_unused_cfg;
  assign w_unused_cfg    = |TIMEOUT_CYCLES;
  assign w_timeout       = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_to_send    <= '0;
      r_rx_byte    <= '0;
      r_spi_done_q <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_to_send    <= w_to_send_nxt;
      r_rx_byte    <= w_rx_byte_nxt;
      r_spi_done_q <= bus.spi_done;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    w_to_send_nxt    = r_to_send;
    w_rx_byte_nxt    = r_rx_byte;
    case (r_state)
      IDLE: begin
        if (|bus.req) begin
          w_state_nxt = OWN;
          if (&bus.req) w_owner_nxt = ~r_last_owner;
          else          w_owner_nxt = bus.req[1];
        end
      end
      OWN: begin
        if (!bus.req[r_owner]) begin
          w_state_nxt      = IDLE;
          w_last_owner_nxt = r_owner;
        end else if (bus.xfer[r_owner]) begin
          w_to_send_nxt = w_tx_sel;
          w_state_nxt   = LOAD;
        end
      end
      LOAD: w_state_nxt = XFER;
      XFER: begin
        if (w_done_rise) begin
          w_rx_byte_nxt = bus.spi_received;
          w_state_nxt   = ACK;
        end else if (w_timeout) begin
          w_rx_byte_nxt = 8'hFF;
          w_state_nxt   = ACK;
        end
      end
      ACK: begin
        if (!bus.xfer[r_owner]) w_state_nxt = OWN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant, done and transmit decode straight from registered state, so reset clears them at once.
  assign bus.gnt          = (r_state != IDLE) ? w_owner_oh : '0;
  assign bus.done_o       = (r_state == ACK)  ? w_owner_oh : '0;
  assign bus.spi_transmit = (r_state == XFER);
  assign bus.spi_to_send  = r_to_send;
  assign bus.rx_byte      = r_rx_byte;

endmodule

// File: doc/spi_bus_arbiter.md
SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 64; the number of clk cycles the block waits for spi_done before aborting a byte (used only with SPI_ARB_TIMEOUT_EN).
REQ-002 Port: clk  in  1  2.08 MHz system clock; all logic on posedge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: req  in  2  bus request per requester, level-sensitive; ownership is held while high.
REQ-005 Port: xfer  in  2  per-requester byte-transfer strobe, level-sensitive (transmit-style handshake).
REQ-006 Port: tx_byte0, tx_byte1  in  8 each  byte to send for requester 0 and requester 1.
REQ-007 Port: gnt  out  2  one-hot grant; all zeros when the bus is free.
REQ-008 Port: done_o  out  2  per-requester byte-complete flag.
REQ-009 Port: rx_byte  out  8  last byte received; valid while any done_o bit is high.
REQ-010 Port: spi_transmit  out  1  transmit input of the shared SPI master.
REQ-011 Port: spi_to_send  out  8  byte-to-send input of the shared SPI master.
REQ-012 Port: spi_done  in  1  done output of the shared SPI master.
REQ-013 Port: spi_received  in  8  received-byte output of the shared SPI master.
REQ-014 Port: timeout_err  out  1  one-cycle abort pulse.

Function
REQ-015 The FSM SHALL have the states IDLE, OWN, LOAD, XFER and ACK.
REQ-016 In IDLE with any req bit high, the block SHALL assert gnt next cycle and enter OWN; on contention it SHALL grant the requester other than last_owner.
REQ-017 In OWN, if req[owner] is low, the block SHALL clear gnt, set last_owner to the owner and enter IDLE in one cycle; a new grant is possible no earlier than the following cycle.
REQ-018 In OWN, if req[owner] and xfer[owner] are both high, the block SHALL register the owner's tx_byte into spi_to_send and enter LOAD.
REQ-019 In LOAD, spi_transmit SHALL stay low for exactly one cycle of setup; the block SHALL then enter XFER.
REQ-020 In XFER, spi_transmit SHALL be high and spi_to_send stable until a rising edge of spi_done, detected against a registered copy of spi_done.
REQ-021 On that spi_done rising edge, the block SHALL capture spi_received into rx_byte, set done_o[owner], drive spi_transmit low next cycle and enter ACK.
REQ-022 In ACK, done_o[owner] SHALL hold until xfer[owner] is low; it SHALL clear the next cycle and the block SHALL return to OWN.
REQ-023 Byte latency: xfer high in OWN to spi_transmit high SHALL be 2 cycles.
REQ-024 A non-granted requester's xfer and tx_byte SHALL be ignored; its done_o SHALL remain 0.
REQ-025 If req[owner] drops during LOAD, XFER or ACK, the current byte SHALL complete normally; the release SHALL happen on return to OWN.
REQ-026 If both req bits rise in the same cycle from reset, requester 0 SHALL win.
REQ-027 gnt and done_o SHALL never have more than one bit set.

Reset
REQ-028 While reset is high, the outputs SHALL be asynchronously forced as follows, with no spurious SCK frame started:
- gnt = 0, done_o = 0, rx_byte = 0x00
- spi_transmit = 0, spi_to_send = 0x00, timeout_err = 0
- state = IDLE, last_owner = 1
REQ-029 A reset asserted mid-XFER SHALL abandon the byte; after release, the block SHALL regrant on the next cycle if req is still high.

Configuration
REQ-030 With macro SPI_ARB_TIMEOUT_EN defined, the block SHALL count cycles in XFER and, on reaching TIMEOUT_CYCLES without a spi_done edge, do the following in the same cycle and then enter ACK:
- drop spi_transmit
- pulse timeout_err for one cycle
- set rx_byte = 0xFF
- set done_o[owner]
REQ-031 With SPI_ARB_TIMEOUT_EN undefined, XFER SHALL wait indefinitely, timeout_err SHALL be tied 0 and no counter SHALL be synthesized.

Verification
REQ-032 req=01, xfer0 high with tx_byte0=0x20, SPI model returns 0x5A after 16 cycles -> spi_to_send=0x20, spi_transmit high 2 cycles after xfer0, then rx_byte=0x5A and done_o=01.
REQ-033 req=11 rising together from reset -> gnt=01; on req0 dropping in OWN -> gnt=00 for one cycle, then gnt=10.
REQ-034 Requester 1 owns the bus, requester 0 toggles xfer0 with tx_byte0=0x38 -> spi_to_send unchanged, done_o[0]=0 throughout.
REQ-035 req0 drops mid-XFER -> byte completes, done_o=01 until xfer0 low, then gnt=00.
REQ-036 SPI_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=64, spi_done held 0 -> spi_transmit low at cycle 64 of XFER, timeout_err pulses once, rx_byte=0xFF, done_o=owner.
REQ-037 reset pulsed mid-XFER -> spi_transmit and gnt go 0 asynchronously; with req held, gnt reasserts 1 cycle after reset release.
